// File: rtl/chess_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : chess_countdown_timer
//  Purpose  : One player's chess clock. Counts down from a preset M:SS, one
//             second per CLOCK_FREQ enabled clock cycles, and decodes the
//             remaining time onto three active-low 7-segment digits.
//  Ports    : clock       - system clock, rising-edge active
//             reset       - asynchronous, active-low; reloads the preset time
//             flag        - count enable (player to move, game live)
//             SegMins     - minutes digit, {g,f,e,d,c,b,a}, active-low
//             SegSecTens  - tens-of-seconds digit (0-5), active-low
//             SegSecUnits - units-of-seconds digit (0-9), active-low
//             Timeout     - high while the remaining time is 0:00
//  Revision : 1.0 - initial release
// ============================================================================
module chess_countdown_timer #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int START_MINS = 5,
  parameter int START_SECS = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flag,
  output logic [6:0] SegMins,
  output logic [6:0] SegSecTens,
  output logic [6:0] SegSecUnits,
  output logic       Timeout
);

  // CLOCK_FREQ >= 2 always gives a width of at least 1; the guard keeps the
  // declaration legal even if someone misconfigures the block.
  localparam int PRE_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;

  localparam logic [PRE_W-1:0] C_PRE_LAST   = PRE_W'(CLOCK_FREQ - 1);
  localparam logic [3:0]       C_MINS_INIT  = 4'(START_MINS);
  localparam logic [2:0]       C_TENS_INIT  = 3'(START_SECS / 10);
  localparam logic [3:0]       C_UNITS_INIT = 4'(START_SECS % 10);

  logic [PRE_W-1:0] pre_q,   pre_d;
  logic [3:0]       mins_q,  mins_d;
  logic [2:0]       tens_q,  tens_d;
  logic [3:0]       units_q, units_d;

  logic w_zero;

  // Active-low 7-segment decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign w_zero = (mins_q == 4'd0) && (tens_q == 3'd0) && (units_q == 4'd0);

  always_comb begin
    pre_d   = pre_q;
    mins_d  = mins_q;
    tens_d  = tens_q;
    units_d = units_q;

    // Pausing (flag=0) freezes the prescaler too, so a partially elapsed
    // second is carried across the pause. At 0:00 everything freezes.
    if (flag && !w_zero) begin
      if (pre_q == C_PRE_LAST) begin
        pre_d = '0;
        // One-second BCD borrow chain. The non-zero guard above ensures the
        // final branch only runs with mins_q > 0, so there is no wrap.
        if (units_q != 4'd0) begin
          units_d = units_q - 4'd1;
        end else begin
          units_d = 4'd9;
          if (tens_q != 3'd0) begin
            tens_d = tens_q - 3'd1;
          end else begin
            tens_d = 3'd5;
            mins_d = mins_q - 4'd1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      mins_q  <= C_MINS_INIT;
      tens_q  <= C_TENS_INIT;
      units_q <= C_UNITS_INIT;
    end else begin
      pre_q   <= pre_d;
      mins_q  <= mins_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign SegMins     = seg7(mins_q);
  assign SegSecTens  = seg7({1'b0, tens_q});
  assign SegSecUnits = seg7(units_q);
  assign Timeout     = w_zero;

endmodule
`default_nettype wire

// File: tb/tb_chess_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chess_countdown_timer
//  Purpose  : Directed self-checking bench for chess_countdown_timer. Four
//             instances with CLOCK_FREQ=4 and presets 5:00, 1:00, 0:02, 0:00
//             share clock and reset, each with its own enable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chess_countdown_timer;

  // Active-low digit codes
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                         S4 = 7'h19, S5 = 7'h12, S7 = 7'h78,
                         S8 = 7'h00, S9 = 7'h10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flag_a = 1'b0, flag_b = 1'b0, flag_c = 1'b0, flag_d = 1'b0;

  logic [6:0] m_a, t_a, u_a, m_b, t_b, u_b, m_c, t_c, u_c, m_d, t_d, u_d;
  logic       to_a, to_b, to_c, to_d;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  chess_countdown_timer #(.CLOCK_FREQ(4), .START_MINS(5), .START_SECS(0)) u_a_dut (
    .clock(clk), .reset(rst_n), .flag(flag_a),
    .SegMins(m_a), .SegSecTens(t_a), .SegSecUnits(u_a), .Timeout(to_a));

  chess_countdown_timer #(.CLOCK_FREQ(4), .START_MINS(1), .START_SECS(0)) u_b_dut (
    .clock(clk), .reset(rst_n), .flag(flag_b),
    .SegMins(m_b), .SegSecTens(t_b), .SegSecUnits(u_b), .Timeout(to_b));

  chess_countdown_timer #(.CLOCK_FREQ(4), .START_MINS(0), .START_SECS(2)) u_c_dut (
    .clock(clk), .reset(rst_n), .flag(flag_c),
    .SegMins(m_c), .SegSecTens(t_c), .SegSecUnits(u_c), .Timeout(to_c));

  chess_countdown_timer #(.CLOCK_FREQ(4), .START_MINS(0), .START_SECS(0)) u_d_dut (
    .clock(clk), .reset(rst_n), .flag(flag_d),
    .SegMins(m_d), .SegSecTens(t_d), .SegSecUnits(u_d), .Timeout(to_d));

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_disp(input string tag,
                          input logic [6:0] m, input logic [6:0] t, input logic [6:0] u,
                          input logic [6:0] em, input logic [6:0] et, input logic [6:0] eu);
    chk({tag, ".mins"},  m, em);
    chk({tag, ".tens"},  t, et);
    chk({tag, ".units"}, u, eu);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #12;
    chk_disp("a_reset", m_a, t_a, u_a, S5, S0, S0);
    chk("a_reset.timeout", {6'd0, to_a}, 7'd0);
    chk_disp("c_reset", m_c, t_c, u_c, S0, S0, S2);
    chk("c_reset.timeout", {6'd0, to_c}, 7'd0);
    chk_disp("d_reset", m_d, t_d, u_d, S0, S0, S0);
    chk("d_reset.timeout", {6'd0, to_d}, 7'd1);

    @(negedge clk);
    rst_n  = 1'b1;
    flag_d = 1'b1;   // 0:00 preset must never move even while enabled

    // ---------------- borrow chain (1:00) ----------------
    @(posedge clk); #1;
    flag_b = 1'b1;
    edges(4);
    chk_disp("b_0_59", m_b, t_b, u_b, S0, S5, S9);
    chk("b_0_59.timeout", {6'd0, to_b}, 7'd0);
    edges(40);
    flag_b = 1'b0;
    chk_disp("b_0_49", m_b, t_b, u_b, S0, S4, S9);

    // ---------------- expiry (0:02) ----------------
    flag_c = 1'b1;
    edges(7);
    chk_disp("c_0_01", m_c, t_c, u_c, S0, S0, S1);
    chk("c_0_01.timeout", {6'd0, to_c}, 7'd0);
    edges(1);
    chk_disp("c_0_00", m_c, t_c, u_c, S0, S0, S0);
    chk("c_0_00.timeout", {6'd0, to_c}, 7'd1);
    edges(20);
    chk_disp("c_nowrap", m_c, t_c, u_c, S0, S0, S0);
    chk("c_nowrap.timeout", {6'd0, to_c}, 7'd1);
    chk_disp("d_hold", m_d, t_d, u_d, S0, S0, S0);
    chk("d_hold.timeout", {6'd0, to_d}, 7'd1);

    // ---------------- first tick and hold (5:00) ----------------
    chk_disp("a_idle", m_a, t_a, u_a, S5, S0, S0);
    flag_a = 1'b1;
    edges(3);
    chk("a_pre_tick.units", u_a, S0);
    edges(1);
    flag_a = 1'b0;
    chk_disp("a_4_59", m_a, t_a, u_a, S4, S5, S9);
    edges(100);
    chk_disp("a_hold", m_a, t_a, u_a, S4, S5, S9);

    // ---------------- pause keeps the fractional second ----------------
    flag_a = 1'b1; edges(2);
    flag_a = 1'b0; edges(10);
    flag_a = 1'b1; edges(1);
    chk("a_frac_early.units", u_a, S9);
    edges(1);
    chk_disp("a_4_58", m_a, t_a, u_a, S4, S5, S8);

    // ---------------- flag low on the would-be tick edge ----------------
    edges(3);                       // prescaler now at its last value
    flag_a = 1'b0; edges(1);
    chk("a_missed_tick.units", u_a, S8);
    flag_a = 1'b1; edges(1);
    chk("a_late_tick.units", u_a, S7);

    // ---------------- run down to 3:17 (100 s) ----------------
    edges(400);
    chk_disp("a_3_17", m_a, t_a, u_a, S3, S1, S7);
    edges(2);                       // leave a partial second in the prescaler
    flag_a = 1'b0;

    // ---------------- asynchronous reset between edges ----------------
    #2 rst_n = 1'b0;
    #1;
    chk_disp("a_async_reset", m_a, t_a, u_a, S5, S0, S0);
    chk("a_async_reset.timeout", {6'd0, to_a}, 7'd0);
    chk("c_async_reset.timeout", {6'd0, to_c}, 7'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    flag_a = 1'b1;
    edges(3);
    chk("a_restart_early.units", u_a, S0);
    edges(1);
    chk_disp("a_restart_4_59", m_a, t_a, u_a, S4, S5, S9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
